// File: rtl/gtx_recover_ctrl.sv
// Per-lane GTX recovery controller: timed reset, bounded ready wait, settle holdoff, then arm the detector.
// Optional GTX_RECOVER_CNT_EN builds the 16-bit saturating recovery counter; otherwise recover_cnt is 0.
module gtx_recover_ctrl #(
   parameter int unsigned RST_CYCLES     = 32,
   parameter int unsigned READY_TIMEOUT  = 156250,
   parameter int unsigned HOLDOFF_CYCLES = 256,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        rst_in,
   input  logic        enable,
   input  logic        request,
   input  logic        gtx_ready,
   output logic        det_start,
   output logic        gtx_reset,
   output logic        busy,
   output logic        fail,
   output logic [15:0] recover_cnt
);

   localparam logic [23:0] RST_LAST  = 24'(RST_CYCLES - 1);
   localparam logic [23:0] TO_LAST   = 24'(READY_TIMEOUT - 1);
   localparam logic [23:0] HOLD_LAST = 24'(HOLDOFF_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_WAIT, S_HOLD, S_MON, S_FAIL
   } state_t;

   state_t      state, state_nx;
   logic [23:0] timer, timer_nx;
   logic [3:0]  retry, retry_nx;

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state     <= S_IDLE;
         timer     <= '0;
         retry     <= '0;
         det_start <= 1'b0;
         gtx_reset <= 1'b0;
         busy      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         retry     <= retry_nx;
         // outputs track the state being entered, so they line up with the state register
         det_start <= (state_nx == S_MON);
         gtx_reset <= (state_nx == S_RESET);
         busy      <= (state_nx == S_RESET) || (state_nx == S_WAIT) || (state_nx == S_HOLD);
         fail      <= (state_nx == S_FAIL);
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer + 24'd1;
      retry_nx = retry;
      case (state)
         S_IDLE: begin
            timer_nx = '0;
            retry_nx = '0;
            if (enable) state_nx = S_RESET;
         end
         S_RESET: begin
            if (timer == RST_LAST) begin
               state_nx = S_WAIT;
               timer_nx = '0;
            end
         end
         S_WAIT: begin
            if (gtx_ready) begin
               state_nx = S_HOLD;
               timer_nx = '0;
               retry_nx = '0;
            end else if (timer == TO_LAST) begin
               retry_nx = retry + 4'd1;
               timer_nx = '0;
               state_nx = (retry + 4'd1 == RETRY_MAX) ? S_FAIL : S_RESET;
            end
         end
         S_HOLD: begin
            if (!gtx_ready) begin
               state_nx = S_WAIT;
               timer_nx = '0;
            end else if (timer == HOLD_LAST) begin
               state_nx = S_MON;
               timer_nx = '0;
            end
         end
         S_MON: begin
            timer_nx = '0;
            if (request || !gtx_ready) state_nx = S_RESET;
         end
         S_FAIL:  timer_nx = '0;
         default: state_nx = S_IDLE;
      endcase
      if (!enable) begin
         state_nx = S_IDLE;
         timer_nx = '0;
         retry_nx = '0;
      end
   end

`ifdef GTX_RECOVER_CNT_EN
   logic [15:0] cnt_q;
   logic        cnt_inc;

   assign cnt_inc = enable && (state == S_MON) && (request || !gtx_ready);

   always_ff @(posedge clk) begin
      if (rst_in)
         cnt_q <= '0;
      else if (cnt_inc && cnt_q != 16'hFFFF)
         cnt_q <= cnt_q + 16'd1;
   end

   assign recover_cnt = cnt_q;
`else
   assign recover_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gtx_recover_ctrl.sv
module tb_gtx_recover_ctrl;

`ifdef GTX_RECOVER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_in, enable, request, gtx_ready;
  logic        det_start, gtx_reset, busy, fail;
  logic [15:0] recover_cnt;

  gtx_recover_ctrl #(
    .RST_CYCLES(4), .READY_TIMEOUT(16), .HOLDOFF_CYCLES(8), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_in(rst_in), .enable(enable), .request(request), .gtx_ready(gtx_ready),
    .det_start(det_start), .gtx_reset(gtx_reset), .busy(busy), .fail(fail),
    .recover_cnt(recover_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           c;
    logic [127:0] tag;
    logic [19:0]  o;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] ecnt   = 16'h0;

  function automatic logic [15:0] ec();
    return CNT_EN ? ecnt : 16'h0000;
  endfunction

  task automatic bump();
    ecnt = (ecnt == 16'hFFFF) ? ecnt : ecnt + 16'd1;
  endtask

  task automatic chk(input int c, input logic [127:0] t, input logic d, input logic r,
                     input logic b, input logic f, input logic [15:0] n);
    exp_t x;
    x.c = c; x.tag = t; x.o = {d, r, b, f, n};
    sb.push_back(x);
  endtask

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic recover(input int n);
    go(n - 1);
    request = 1'b1;
    bump();
    chk(n,      "rcv_rst",  0, 1, 1, 0, ec());
    chk(n + 3,  "rcv_rend", 0, 1, 1, 0, ec());
    chk(n + 4,  "rcv_wait", 0, 0, 1, 0, ec());
    chk(n + 12, "rcv_hold", 0, 0, 1, 0, ec());
    chk(n + 13, "rcv_mon",  1, 0, 0, 0, ec());
    go(n);
    request = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.c != cyc || {det_start, gtx_reset, busy, fail, recover_cnt} !== e.o) begin
        fails++;
        $display("FAIL %0s cyc=%0d got d/r/b/f/cnt=%b%b%b%b/%h want %b%b%b%b/%h",
                 e.tag, cyc, det_start, gtx_reset, busy, fail, recover_cnt,
                 e.o[19], e.o[18], e.o[17], e.o[16], e.o[15:0]);
      end
    end
  end

  initial begin
    rst_in = 1'b1; enable = 1'b0; request = 1'b0; gtx_ready = 1'b0;
    go(2);
    rst_in = 1'b0;
    chk(2, "rst_state", 0, 0, 0, 0, 16'h0);
    chk(3, "idle",      0, 0, 0, 0, 16'h0);

    go(4);
    enable = 1'b1;
    chk(5, "brst_on",  0, 1, 1, 0, ec());
    chk(8, "brst_end", 0, 1, 1, 0, ec());
    chk(9, "bwait",    0, 0, 1, 0, ec());
    go(14);
    gtx_ready = 1'b1;
    chk(22, "bhold", 0, 0, 1, 0, ec());
    chk(23, "bmon",  1, 0, 0, 0, ec());

    recover(26);
    recover(40);
    recover(54);

    go(67);
    request = 1'b1; gtx_ready = 1'b0;
    bump();
    chk(68, "both",      0, 1, 1, 0, ec());
    chk(72, "both_wait", 0, 0, 1, 0, ec());
    go(68);
    request = 1'b0;
    go(74);
    gtx_ready = 1'b1;
    go(78);
    gtx_ready = 1'b0;
    chk(79, "glitch_wait", 0, 0, 1, 0, ec());
    go(79);
    gtx_ready = 1'b1;
    chk(83, "glitch_hold", 0, 0, 1, 0, ec());
    chk(87, "hold_full",   0, 0, 1, 0, ec());
    chk(88, "glitch_mon",  1, 0, 0, 0, ec());

    go(89);
    request = 1'b1;
    bump();
    chk(90, "p5_rst",  0, 1, 1, 0, ec());
    chk(91, "p5_rst2", 0, 1, 1, 0, ec());
    go(90);
    request = 1'b0;
    go(91);
    rst_in = 1'b1;
    chk(92, "rst_mid", 0, 0, 0, 0, 16'h0);
    go(92);
    rst_in = 1'b0;
    ecnt = 16'h0;
    chk(93,  "rst_rearm", 0, 1, 1, 0, ec());
    chk(106, "rst_mon",   1, 0, 0, 0, ec());

    go(107);
`ifdef GTX_RECOVER_CNT_EN
    force dut.cnt_q = 16'hFFFF;
    go(108);
    release dut.cnt_q;
    ecnt = 16'hFFFF;
`else
    go(108);
`endif
    chk(109, "sat_pre", 1, 0, 0, 0, ec());
    go(109);
    request = 1'b1;
    bump();
    chk(110, "sat", 0, 1, 1, 0, ec());
    go(110);
    request = 1'b0;
    chk(123, "sat_mon", 1, 0, 0, 0, ec());

    go(124);
    gtx_ready = 1'b0;
    bump();
    chk(125, "to_p1",     0, 1, 1, 0, ec());
    chk(144, "to_w1",     0, 0, 1, 0, ec());
    chk(145, "to_p2",     0, 1, 1, 0, ec());
    chk(165, "to_p3",     0, 1, 1, 0, ec());
    chk(184, "to_w3",     0, 0, 1, 0, ec());
    chk(185, "fail",      0, 0, 0, 1, ec());
    chk(200, "fail_hold", 0, 0, 0, 1, ec());
    go(200);
    checks++;
    if ({gtx_reset, fail} !== 2'b01) begin
      fails++;
      $display("FAIL fail_direct cyc=%0d gtx_reset=%b fail=%b", cyc, gtx_reset, fail);
    end
    enable = 1'b0;
    chk(201, "fail_clr", 0, 0, 0, 0, ec());
    go(201);
    checks++;
    if ({det_start, fail} !== 2'b00) begin
      fails++;
      $display("FAIL idle_direct cyc=%0d det_start=%b fail=%b", cyc, det_start, fail);
    end
    go(203);
    enable = 1'b1;
    chk(204, "reen", 0, 1, 1, 0, ec());

    go(cyc + 3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      fails++;
      $display("FAIL %0s never checked (cycle %0d)", e.tag, e.c);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    if (fails != 0) $display("TEST FAILED");
    else            $display("TEST PASSED");
    $finish;
  end

endmodule

// File: doc/gtx_recover_ctrl.md
# gtx_recover_ctrl

Recovery controller on the opposite side of the GTX link-error detector's request handshake. It drives the detector's `start` input, consumes its sticky `request` output, and answers each request with a timed GTX reset, a bounded wait for the transceiver to come ready, and a settle holdoff before re-arming detection. It sits between the detector and the GTX reset and ready pins, one instance per fiber lane. It declares a hard failure after repeated bring-up timeouts.

## Interface
Parameters:
- `RST_CYCLES`, default 32: width of the `gtx_reset` pulse in clk cycles; legal range 1..2^24-1.
- `READY_TIMEOUT`, default 156250: cycles to wait for `gtx_ready` after a reset (1 ms at 156.25 MHz); legal range 2..2^24-1.
- `HOLDOFF_CYCLES`, default 256: cycles for which `gtx_ready` must stay high before detection is armed; legal range 1..2^24-1.
- `MAX_RETRY`, default 3: consecutive ready-timeouts that force FAIL; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `enable`  in  1  lane enable; low forces IDLE.
- `request`  in  1  detector request; sticky while `det_start` is high.
- `gtx_ready`  in  1  GTX reset-done AND PLL-lock, already synchronous to `clk`.
- `det_start`  out  1  detector start/arm.
- `gtx_reset`  out  1  GTX reset, active-high.
- `busy`  out  1  recovery in progress.
- `fail`  out  1  bring-up failed; sticky until `enable` is low.
- `recover_cnt`  out  16  saturating count of recoveries triggered in MONITOR.

## Operation
- States: IDLE, RESET, WAIT_READY, HOLDOFF, MONITOR, FAIL. The block has one shared 24-bit timer and a 4-bit retry counter.
- Every output is registered and decoded from the current state:
  - `det_start` = (MONITOR).
  - `gtx_reset` = (RESET).
  - `busy` = (RESET | WAIT_READY | HOLDOFF).
  - `fail` = (FAIL).
- IDLE: `enable`=1 moves to RESET; the timer and retry counter are cleared.
- RESET: the timer counts from 0. At timer = RST_CYCLES-1 the block moves to WAIT_READY and clears the timer.
- WAIT_READY:
  - `gtx_ready`=1 moves to HOLDOFF, clears the timer and clears the retry counter.
  - If the timer reaches READY_TIMEOUT-1 with `gtx_ready` still low, the retry counter increments. If the new value equals MAX_RETRY the block moves to FAIL; otherwise it moves to RESET.
  - If `gtx_ready` goes high on the same cycle the timer reaches READY_TIMEOUT-1, ready wins.
- HOLDOFF:
  - `gtx_ready`=0 returns to WAIT_READY with the timer cleared.
  - At timer = HOLDOFF_CYCLES-1 with `gtx_ready` high, the block moves to MONITOR.
- MONITOR:
  - `request`=1 or `gtx_ready`=0 moves to RESET and increments `recover_cnt` once, even if both are asserted together.
  - `request` is ignored in every other state. Dropping `det_start` clears the detector's sticky request, so a single request cannot be counted twice.
- FAIL: `gtx_reset`=0 and `det_start`=0. The block stays in FAIL until `enable`=0.
- `enable`=0 in any state moves to IDLE on the next edge and clears the timer and retry counter. `recover_cnt` is not cleared.
- `recover_cnt` saturates at 16'hFFFF.

## Timing
- `rst_in`=1 on an edge: state is IDLE, all outputs are 0, and all counters are 0. This holds mid-operation too, including while `gtx_reset` is high; `gtx_reset` drops on the edge that samples reset.
- `enable` sampled high at edge E0: `gtx_reset`=1 from E0+1 through E0+RST_CYCLES, with state WAIT_READY at E0+RST_CYCLES+1.
- `request` sampled in MONITOR at edge N:
  - `det_start`=0 and `gtx_reset`=1 from N+1.
  - `recover_cnt` is updated at N+1.
  - `gtx_reset` stays high for exactly RST_CYCLES cycles.
- `gtx_ready` first sampled high at edge R with the block in WAIT_READY: `det_start`=1 at R+HOLDOFF_CYCLES+1, provided `gtx_ready` stays high throughout.
- Minimum `det_start` low gap between two MONITOR periods: RST_CYCLES+HOLDOFF_CYCLES+1 cycles.

## Configuration
- `GTX_RECOVER_CNT_EN` defined: the 16-bit saturating `recover_cnt` register is implemented as described.
- `GTX_RECOVER_CNT_EN` undefined: no counter register is implemented, `recover_cnt` is tied to 16'h0000, and all other behaviour is identical.

## Test plan
- Bring-up: set RST_CYCLES=4, HOLDOFF_CYCLES=8. Raise `enable` at E0 and `gtx_ready` at E0+10.
  - Required: `gtx_reset` is high for E0+1..E0+4.
  - Required: `det_start` rises at E0+19.
  - Required: `busy` is low from E0+19.
- Recovery: in MONITOR, pulse `request` for 1 cycle. Required: `det_start` falls, `gtx_reset` is high for 4 cycles, and `recover_cnt` goes 0→1. Repeat 3 times → `recover_cnt`=3.
- Timeouts: set READY_TIMEOUT=16, MAX_RETRY=3, and hold `gtx_ready`=0. Required: 3 reset pulses, then `fail`=1 and `gtx_reset`=0 indefinitely. Dropping `enable` returns to IDLE with `fail`=0.
- HOLDOFF glitch: drop `gtx_ready` for 1 cycle mid-HOLDOFF. Required: state returns to WAIT_READY, `det_start` stays 0, holdoff restarts in full, and `recover_cnt` is unchanged.
- Reset and edge cases:
  - Assert `rst_in` for 1 cycle while `gtx_reset`=1. Required: all outputs are 0 on the next cycle.
  - Assert `request` and drop `gtx_ready` together in MONITOR. Required: `recover_cnt` increments by exactly 1.
  - With the counter forced to 16'hFFFF, a further request leaves it at 16'hFFFF.
  - With `GTX_RECOVER_CNT_EN` undefined, `recover_cnt` reads 0 throughout.
